ram_port_arbiter: RTL and testbench

Shares one single-ported, registered-output 32-bit BRAM between the MMU's instruction and data RAM channels. Accepts ready-valid requests from both, grants one per cycle by round-robin, drives the BRAM port, and routes read data back on per-requester ready-valid response channels. It sits between the MMU's RAM-controller ports and the BRAM macro.

---
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-output BRAM port between the instruction and
// data RAM channels, with a one-entry hold buffer for stalled read responses.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_iaddr_v,
    output logic                  o_iaddr_r,
    input  logic [ADDR_WIDTH-1:0] i_iaddr,
    output logic                  o_irdata_v,
    input  logic                  i_irdata_r,
    output logic [31:0]           o_irdata,
    input  logic                  i_daddr_v,
    output logic                  o_daddr_r,
    input  logic [ADDR_WIDTH-1:0] i_daddr,
    input  logic [3:0]            i_dwstrb,
    input  logic [31:0]           i_dwdata,
    output logic                  o_drdata_v,
    input  logic                  i_drdata_r,
    output logic [31:0]           o_drdata,
    output logic                  o_mem_en,
    output logic [3:0]            o_mem_we,
    output logic [ADDR_WIDTH-3:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);

    localparam logic SrcI = 1'b0;
    localparam logic SrcD = 1'b1;

    logic        rd_pend_q, rd_pend_d;
    logic        rd_src_q, rd_src_d;
    logic        hold_v_q, hold_v_d;
    logic        hold_src_q, hold_src_d;
    logic        rr_last_q, rr_last_d;
    logic [31:0] hold_data_q, hold_data_d;

    logic        rsp_v, rsp_src, rsp_rdy, rsp_fire, slot_ok;
    logic        d_write, elig_i, elig_d, gnt_i, gnt_d;
    logic [31:0] rsp_data;

    always_comb begin
        rsp_v    = rd_pend_q | hold_v_q;
        rsp_src  = hold_v_q ? hold_src_q : rd_src_q;
        rsp_data = hold_v_q ? hold_data_q : i_mem_rdata;
        rsp_rdy  = (rsp_src == SrcD) ? i_drdata_r : i_irdata_r;
        rsp_fire = rsp_v & rsp_rdy;
        slot_ok  = !rsp_v | rsp_fire;

        // Writes never occupy the response slot, so they bypass the stall.
        d_write = |i_dwstrb;
        elig_i  = i_rst_n & i_iaddr_v & slot_ok;
        elig_d  = i_rst_n & i_daddr_v & (d_write | slot_ok);
        gnt_d   = elig_d & (!elig_i | (rr_last_q == SrcI));
        gnt_i   = elig_i & (!elig_d | (rr_last_q == SrcD));

        o_iaddr_r   = gnt_i;
        o_daddr_r   = gnt_d;
        o_mem_en    = gnt_i | gnt_d;
        o_mem_we    = (gnt_d & d_write) ? i_dwstrb : 4'b0000;
        o_mem_wdata = gnt_d ? i_dwdata : 32'h0;
        o_mem_addr  = '0;
        if (gnt_i) begin
            o_mem_addr = i_iaddr[ADDR_WIDTH-1:2];
        end else if (gnt_d) begin
            o_mem_addr = i_daddr[ADDR_WIDTH-1:2];
        end

        o_irdata_v = rsp_v & (rsp_src == SrcI);
        o_drdata_v = rsp_v & (rsp_src == SrcD);
        o_irdata   = rsp_v ? rsp_data : 32'h0;
        o_drdata   = rsp_v ? rsp_data : 32'h0;

        rr_last_d = rr_last_q;
        if (gnt_d) begin
            rr_last_d = SrcD;
        end else if (gnt_i) begin
            rr_last_d = SrcI;
        end

        rd_pend_d = gnt_i | (gnt_d & !d_write);
        rd_src_d  = gnt_d ? SrcD : SrcI;

        // BRAM output is only valid for one cycle; park it if the consumer stalls.
        hold_v_d    = hold_v_q;
        hold_src_d  = hold_src_q;
        hold_data_d = hold_data_q;
        if (rd_pend_q && !rsp_fire && !hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_src_d  = rd_src_q;
            hold_data_d = i_mem_rdata;
        end else if (hold_v_q && rsp_fire) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_q   <= 1'b0;
            rd_src_q    <= SrcI;
            hold_v_q    <= 1'b0;
            hold_src_q  <= SrcI;
            hold_data_q <= 32'h0;
            rr_last_q   <= SrcI;
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_src_q    <= rd_src_d;
            hold_v_q    <= hold_v_d;
            hold_src_q  <= hold_src_d;
            hold_data_q <= hold_data_d;
            rr_last_q   <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: BRAM model, expected responses queued at issue time
// and checked by an independent response monitor.
module tb_ram_port_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_iaddr_v, o_iaddr_r, o_irdata_v, i_irdata_r;
    logic [AW-1:0] i_iaddr, i_daddr;
    logic          i_daddr_v, o_daddr_r, o_drdata_v, i_drdata_r;
    logic [3:0]    i_dwstrb, o_mem_we;
    logic [31:0]   i_dwdata, o_irdata, o_drdata, o_mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic          o_mem_en;
    logic [AW-3:0] o_mem_addr;
    logic          preload;

    logic [31:0]   mem [0:(1<<(AW-2))-1];

    int            checks = 0;
    int            errors = 0;
    logic [32:0]   exp_q[$];

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_iaddr_v(i_iaddr_v), .o_iaddr_r(o_iaddr_r), .i_iaddr(i_iaddr),
        .o_irdata_v(o_irdata_v), .i_irdata_r(i_irdata_r), .o_irdata(o_irdata),
        .i_daddr_v(i_daddr_v), .o_daddr_r(o_daddr_r), .i_daddr(i_daddr),
        .i_dwstrb(i_dwstrb), .i_dwdata(i_dwdata),
        .o_drdata_v(o_drdata_v), .i_drdata_r(i_drdata_r), .o_drdata(o_drdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // BRAM model: byte-enabled writes, registered read data updated only on reads.
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'hDEADBEEF;
            mem[5] <= 32'h55555555;
            mem[6] <= 32'h66666666;
            mem[7] <= 32'h77777777;
            mem[8] <= 32'hAAAAAAAA;
        end else if (o_mem_en) begin
            if (o_mem_we == 4'b0000) mem_rdata <= mem[o_mem_addr];
            for (int b = 0; b < 4; b++)
                if (o_mem_we[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_iaddr_r"}, 32'(o_iaddr_r), 0);
        check({tag, "_daddr_r"}, 32'(o_daddr_r), 0);
        check({tag, "_irdata_v"}, 32'(o_irdata_v), 0);
        check({tag, "_drdata_v"}, 32'(o_drdata_v), 0);
        check({tag, "_irdata"}, o_irdata, 0);
        check({tag, "_drdata"}, o_drdata, 0);
        check({tag, "_mem_en"}, 32'(o_mem_en), 0);
        check({tag, "_mem_we"}, 32'(o_mem_we), 0);
        check({tag, "_mem_addr"}, 32'(o_mem_addr), 0);
        check({tag, "_mem_wdata"}, o_mem_wdata, 0);
    endtask

    // Response monitor: pops one expectation per fired response.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n === 1'b1) begin
            check("rsp_one_hot", 32'(o_irdata_v & o_drdata_v), 0);
            if ((o_irdata_v & i_irdata_r) | (o_drdata_v & i_drdata_r)) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(o_drdata_v), 32'(o_irdata_v));
                    check("rsp_unexpected_q", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_src", 32'(o_drdata_v), 32'(e[32]));
                    check("rsp_data", o_drdata_v ? o_drdata : o_irdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        i_iaddr_v = 1'b1; i_daddr_v = 1'b1; i_dwstrb = 4'hF;
        i_iaddr = 16'h0010; i_daddr = 16'h0020; i_dwdata = 32'h0;
        i_irdata_r = 1'b0; i_drdata_r = 1'b0;
        samp();
        check_zero("reset");
        step();
        preload = 1'b0; rst_n = 1'b1;
        i_iaddr_v = 1'b0; i_daddr_v = 1'b0; i_dwstrb = 4'h0;
        i_irdata_r = 1'b1; i_drdata_r = 1'b1;

        // Single instruction read.
        i_iaddr_v = 1'b1; i_iaddr = 16'h0010;
        samp();
        check("t1_iaddr_r", 32'(o_iaddr_r), 1);
        check("t1_mem_en", 32'(o_mem_en), 1);
        check("t1_mem_addr", 32'(o_mem_addr), 4);
        check("t1_mem_we", 32'(o_mem_we), 0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        step();
        i_iaddr_v = 1'b0;
        samp();
        check("t1_rsp_v", 32'(o_irdata_v), 1);
        step();
        samp();
        check("t1_rsp_once", 32'(o_irdata_v), 0);
        step();

        // Contended reads alternate D, I, D, I.
        i_iaddr_v = 1'b1; i_iaddr = 16'h0014;
        i_daddr_v = 1'b1; i_daddr = 16'h0018; i_dwstrb = 4'h0;
        for (int k = 0; k < 4; k++) begin
            samp();
            check("t2_gnt_d", 32'(o_daddr_r), 32'(k % 2 == 0));
            check("t2_gnt_i", 32'(o_iaddr_r), 32'(k % 2 == 1));
            if (k % 2 == 0) exp_q.push_back({1'b1, 32'h66666666});
            else            exp_q.push_back({1'b0, 32'h55555555});
            step();
        end

        // Partial write then read-back.
        i_iaddr_v = 1'b0;
        i_daddr = 16'h0020; i_dwstrb = 4'b0011; i_dwdata = 32'h12345678;
        samp();
        check("t3_wr_gnt", 32'(o_daddr_r), 1);
        check("t3_wr_we", 32'(o_mem_we), 32'h3);
        check("t3_wr_addr", 32'(o_mem_addr), 8);
        check("t3_wr_wdata", o_mem_wdata, 32'h12345678);
        step();
        i_dwstrb = 4'b0000;
        samp();
        check("t3_no_wr_rsp", 32'(o_drdata_v), 0);
        check("t3_rd_gnt", 32'(o_daddr_r), 1);
        check("t3_rd_we", 32'(o_mem_we), 0);
        exp_q.push_back({1'b1, 32'hAAAA5678});
        step();
        i_daddr_v = 1'b0;

        // Stalled instruction response: reads blocked, writes pass.
        i_irdata_r = 1'b0; i_iaddr_v = 1'b1; i_iaddr = 16'h001C;
        samp();
        check("t4_i_gnt", 32'(o_iaddr_r), 1);
        exp_q.push_back({1'b0, 32'h77777777});
        step();
        i_iaddr_v = 1'b0; i_daddr_v = 1'b1; i_daddr = 16'h0010; i_dwstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                i_daddr = 16'h0024; i_dwstrb = 4'hF; i_dwdata = 32'h99999999;
            end
            samp();
            check("t4_hold_v", 32'(o_irdata_v), 1);
            check("t4_hold_data", o_irdata, 32'h77777777);
            check("t4_d_gnt", 32'(o_daddr_r), 32'(k == 1));
            if (k == 1) check("t4_wr_we", 32'(o_mem_we), 32'hF);
            step();
            i_daddr = 16'h0010; i_dwstrb = 4'h0;
        end
        i_irdata_r = 1'b1;
        samp();
        check("t4_rd_same_cycle", 32'(o_daddr_r), 1);
        check("t4_rd_addr", 32'(o_mem_addr), 4);
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        step();
        i_daddr_v = 1'b0;

        // Reset with a held response; it must be dropped.
        i_irdata_r = 1'b0; i_iaddr_v = 1'b1; i_iaddr = 16'h0010;
        samp();
        check("t5_i_gnt", 32'(o_iaddr_r), 1);
        step();
        i_iaddr_v = 1'b0;
        step();
        samp();
        check("t5_held_v", 32'(o_irdata_v), 1);
        i_iaddr_v = 1'b1; i_daddr_v = 1'b1; i_dwstrb = 4'hF;
        #1 rst_n = 1'b0;
        #1 check_zero("t5_rst");
        step();
        rst_n = 1'b1; i_irdata_r = 1'b1;
        i_iaddr_v = 1'b0; i_daddr_v = 1'b0; i_dwstrb = 4'h0;
        samp();
        check("t5_no_stale_i", 32'(o_irdata_v), 0);
        check("t5_no_stale_d", 32'(o_drdata_v), 0);
        step();

        // First tie after reset goes to D; unaligned I address ignores low bits.
        i_iaddr_v = 1'b1; i_iaddr = 16'h0013;
        i_daddr_v = 1'b1; i_daddr = 16'h0024; i_dwstrb = 4'h0;
        samp();
        check("t6_tie_d", 32'(o_daddr_r), 1);
        check("t6_tie_i", 32'(o_iaddr_r), 0);
        check("t6_d_addr", 32'(o_mem_addr), 9);
        exp_q.push_back({1'b1, 32'h99999999});
        step();
        i_daddr_v = 1'b0;
        samp();
        check("t6_i_gnt", 32'(o_iaddr_r), 1);
        check("t6_unaligned_addr", 32'(o_mem_addr), 4);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        step();
        i_iaddr_v = 1'b0;

        repeat (3) step();
        check("all_rsp_seen", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
